// File: rtl/param_register_file_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for param_register_file:
//   - state_t      : FSM state (INIT fills the array, RUN is normal operation)
//   - DEF_*        : default parameter values for the register file
//   - init_value() : value written to register[index] during the init fill
// -----------------------------------------------------------------------------
package regfile_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_DATA_W    = 32;
   localparam int DEF_DEPTH     = 32;
   localparam int DEF_NUM_RD    = 2;
   localparam int DEF_ZERO_REG  = 1;
   localparam int DEF_INIT_MODE = 1;
   localparam int DEF_BYPASS    = 1;

   // mode 0: all zeros, mode 1: each register holds its own index
   function automatic int init_value(input int index, input int mode);
      return (mode == 1) ? index : 0;
   endfunction

endpackage

// File: rtl/param_register_file.sv
// -----------------------------------------------------------------------------
// param_register_file
// Parameterized register file: one write port, NUM_RD combinational read ports.
// After reset an init sequence walks every address once (DEPTH cycles) and
// fills it with init_value(); only then does the file accept writes and return
// stored data.
//
// Ports:
//   clk    in   clock, all state on rising edge
//   rst    in   synchronous active-high reset (restarts the init fill)
//   A3     in   write address
//   WE3    in   write enable (ignored during init)
//   WD3    in   write data
//   A_RD   in   packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   RD     out  packed read data,     port k at [k*DATA_W +: DATA_W]
//   ready  out  registered; high once the init fill has completed
// -----------------------------------------------------------------------------
module param_register_file
   import regfile_pkg::*;
#(
   parameter  int DATA_W    = DEF_DATA_W,
   parameter  int DEPTH     = DEF_DEPTH,
   parameter  int NUM_RD    = DEF_NUM_RD,
   parameter  int ZERO_REG  = DEF_ZERO_REG,
   parameter  int INIT_MODE = DEF_INIT_MODE,
   parameter  int BYPASS    = DEF_BYPASS,
   localparam int ADDR_W    = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_W-1:0]          A3,
   input  logic                       WE3,
   input  logic [DATA_W-1:0]          WD3,
   input  logic [NUM_RD*ADDR_W-1:0]   A_RD,
   output logic [NUM_RD*DATA_W-1:0]   RD,
   output logic                       ready
);

   // One extra bit so DEPTH itself is representable for range checks
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   state_t              r_state;
   state_t              w_next_state;
   logic [ADDR_W-1:0]   r_cnt;
   logic                r_ready;
   logic [DATA_W-1:0]   r_mem [DEPTH];

   logic                w_init_we;
   logic                w_run_we;
   logic                w_a3_ok;
   logic [DATA_W-1:0]   w_init_data;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= INIT;
         r_cnt   <= '0;
         r_ready <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_ready <= (w_next_state == RUN);
         // Counter is only meaningful in INIT; it is parked once RUN is reached
         if (r_state == INIT)
            r_cnt <= r_cnt + ADDR_W'(1);
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         INIT:    if (r_cnt == LAST) w_next_state = RUN;
         RUN:     w_next_state = RUN;
         default: w_next_state = INIT;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   // Writes are suppressed on a reset edge so a held reset never touches the
   // array; the same gate keeps forwarding consistent with what commits.
   always_comb begin
      w_a3_ok     = ({1'b0, A3} < DEPTH_L) && !((ZERO_REG != 0) && (A3 == '0));
      w_init_we   = (r_state == INIT) && !rst;
      w_run_we    = (r_state == RUN) && !rst && WE3 && w_a3_ok;
      w_init_data = DATA_W'(init_value(int'({1'b0, r_cnt}), INIT_MODE));
   end

   assign ready = r_ready;

   // ---------------------------------------------------------------- array
   // No reset on the storage: contents are defined by the init fill.
   always_ff @(posedge clk) begin
      if (w_init_we)
         r_mem[r_cnt] <= w_init_data;
      else if (w_run_we)
         r_mem[A3] <= WD3;
   end

   // ---------------------------------------------------------------- reads
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_rd;

      assign w_addr = A_RD[k*ADDR_W +: ADDR_W];

      always_comb begin
         w_rd = '0;
         if ((r_state == RUN) && ({1'b0, w_addr} < DEPTH_L) &&
             !((ZERO_REG != 0) && (w_addr == '0))) begin
            if ((BYPASS != 0) && w_run_we && (A3 == w_addr))
               w_rd = WD3;
            else
               w_rd = r_mem[w_addr];
         end
      end

      assign RD[k*DATA_W +: DATA_W] = w_rd;
   end

endmodule

// File: tb/tb_param_register_file.sv
module tb_param_register_file;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // DUT A: all defaults (32x32, 2 ports, zero reg, index fill, bypass)
   logic        a_rst = 1'b1, a_we = 1'b0;
   logic [4:0]  a_a3  = '0;
   logic [31:0] a_wd  = '0;
   logic [9:0]  a_ard = '0;
   logic [63:0] a_rd;
   logic        a_ready;

   // DUT B: parameter sweep, 16-bit x 24, 4 ports
   logic        b_rst = 1'b1, b_we = 1'b0;
   logic [4:0]  b_a3  = '0;
   logic [15:0] b_wd  = '0;
   logic [19:0] b_ard = '0;
   logic [63:0] b_rd;
   logic        b_ready;

   // DUT C: no zero reg, zero fill, no bypass
   logic        c_rst = 1'b1, c_we = 1'b0;
   logic [4:0]  c_a3  = '0;
   logic [31:0] c_wd  = '0;
   logic [9:0]  c_ard = '0;
   logic [63:0] c_rd;
   logic        c_ready;

   param_register_file u_a (
      .clk(clk), .rst(a_rst), .A3(a_a3), .WE3(a_we), .WD3(a_wd),
      .A_RD(a_ard), .RD(a_rd), .ready(a_ready));

   param_register_file #(.DATA_W(16), .DEPTH(24), .NUM_RD(4)) u_b (
      .clk(clk), .rst(b_rst), .A3(b_a3), .WE3(b_we), .WD3(b_wd),
      .A_RD(b_ard), .RD(b_rd), .ready(b_ready));

   param_register_file #(.ZERO_REG(0), .INIT_MODE(0), .BYPASS(0)) u_c (
      .clk(clk), .rst(c_rst), .A3(c_a3), .WE3(c_we), .WD3(c_wd),
      .A_RD(c_ard), .RD(c_rd), .ready(c_ready));

   // Reference contents as the spec defines them (architectural view)
   logic [31:0] m_a [32];
   logic [31:0] m_c [32];

   // Expected read of A: register 0 is hardwired zero, a same-cycle legal
   // write is visible, otherwise the stored value.
   function automatic logic [31:0] ref_a(input logic [4:0] addr);
      if (addr == 5'd0)                 return 32'd0;
      if (a_we && a_a3 == addr)         return a_wd;
      return m_a[addr];
   endfunction

   initial begin
      #400000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1, "timeout");
   end

   // ------------------------------------------------------------------ reset
   task automatic test_reset();
      int na, nb, nc;
      na = 0; nb = 0; nc = 0;
      a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      a_ard = {5'd5, 5'd3};
      #1;
      n_tests++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0 || c_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready: got a=%b b=%b c=%b expected 0", a_ready, b_ready, c_ready);
      end
      n_tests++;
      if (a_rd !== 64'd0) begin
         n_fail++;
         $display("FAIL reset_rd_zero: got %h expected 0", a_rd);
      end
      a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         a_we = (cyc == 10); a_a3 = 5'd3; a_wd = 32'hFF;
         @(posedge clk); @(negedge clk); #1;
         if (a_ready && na == 0) na = cyc;
         if (b_ready && nb == 0) nb = cyc;
         if (c_ready && nc == 0) nc = cyc;
         if (cyc == 15) begin
            n_tests++;
            if (a_rd !== 64'd0) begin
               n_fail++;
               $display("FAIL init_rd_zero: got %h expected 0", a_rd);
            end
         end
         if (na != 0 && nb != 0 && nc != 0) break;
      end
      a_we = 1'b0;
      n_tests++;
      if (na != 32) begin
         n_fail++;
         $display("FAIL init_len_a: got %0d expected 32", na);
      end
      n_tests++;
      if (nb != 24) begin
         n_fail++;
         $display("FAIL init_len_b: got %0d expected 24", nb);
      end
      n_tests++;
      if (nc != 32) begin
         n_fail++;
         $display("FAIL init_len_c: got %0d expected 32", nc);
      end
      for (int i = 0; i < 32; i++) begin
         m_a[i] = 32'(i);
         m_c[i] = 32'd0;
      end
      // reg 3 must hold its fill value: the write during INIT was dropped
      a_ard = {5'd5, 5'd3};
      c_ard = {5'd5, 5'd3};
      b_ard = {5'd23, 5'd3, 5'd2, 5'd1};
      #1;
      n_tests++;
      if (a_rd !== {32'd5, 32'd3}) begin
         n_fail++;
         $display("FAIL init_vals_a: got %h expected %h", a_rd, {32'd5, 32'd3});
      end
      n_tests++;
      if (c_rd !== 64'd0) begin
         n_fail++;
         $display("FAIL init_vals_c: got %h expected 0", c_rd);
      end
      n_tests++;
      if (b_rd !== {16'd23, 16'd3, 16'd2, 16'd1}) begin
         n_fail++;
         $display("FAIL init_vals_b: got %h expected %h", b_rd, {16'd23, 16'd3, 16'd2, 16'd1});
      end
   endtask

   // ------------------------------------------------------------------ bypass
   task automatic test_bypass();
      @(negedge clk);
      a_we = 1'b1; a_a3 = 5'd7; a_wd = 32'hDEADBEEF; a_ard = {5'd1, 5'd7};
      #1;
      n_tests++;
      if (a_rd !== {32'd1, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL bypass_a: got %h expected %h", a_rd, {32'd1, 32'hDEADBEEF});
      end
      @(posedge clk);
      m_a[7] = 32'hDEADBEEF;
      @(negedge clk);
      a_we = 1'b0;
      #1;
      n_tests++;
      if (a_rd[31:0] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL bypass_commit_a: got %h expected deadbeef", a_rd[31:0]);
      end
      // without forwarding the old value is seen until the committing edge
      c_we = 1'b1; c_a3 = 5'd7; c_wd = 32'hDEADBEEF; c_ard = {5'd7, 5'd7};
      #1;
      n_tests++;
      if (c_rd !== {m_c[7], m_c[7]}) begin
         n_fail++;
         $display("FAIL nobypass_old_c: got %h expected %h", c_rd, {m_c[7], m_c[7]});
      end
      @(posedge clk);
      m_c[7] = 32'hDEADBEEF;
      #1;
      n_tests++;
      if (c_rd !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
         n_fail++;
         $display("FAIL nobypass_new_c: got %h expected deadbeefdeadbeef", c_rd);
      end
      @(negedge clk);
      c_we = 1'b0;
   endtask

   // ------------------------------------------------------------------ zero reg
   task automatic test_zero_reg();
      @(negedge clk);
      a_we = 1'b1; a_a3 = 5'd0; a_wd = 32'h1234; a_ard = '0;
      c_we = 1'b1; c_a3 = 5'd0; c_wd = 32'h1234; c_ard = '0;
      #1;
      n_tests++;
      if (a_rd !== 64'd0) begin
         n_fail++;
         $display("FAIL zero_reg_same_a: got %h expected 0", a_rd);
      end
      @(posedge clk);
      m_c[0] = 32'h1234;
      @(negedge clk);
      a_we = 1'b0; c_we = 1'b0;
      #1;
      n_tests++;
      if (a_rd !== 64'd0) begin
         n_fail++;
         $display("FAIL zero_reg_after_a: got %h expected 0", a_rd);
      end
      n_tests++;
      if (c_rd !== {32'h1234, 32'h1234}) begin
         n_fail++;
         $display("FAIL zero_reg_off_c: got %h expected %h", c_rd, {32'h1234, 32'h1234});
      end
   endtask

   // ------------------------------------------------------------------ random
   task automatic test_random();
      logic [4:0]  addr;
      logic [31:0] exp;
      for (int it = 0; it < 300; it++) begin
         @(negedge clk);
         a_we = 1'($urandom_range(0, 1));
         a_a3 = 5'($urandom);
         a_wd = $urandom;
         addr = 5'($urandom);
         for (int k = 0; k < 2; k++) begin
            case ($urandom_range(0, 3))
               0:       a_ard[k*5 +: 5] = a_a3;
               1:       a_ard[k*5 +: 5] = addr;
               default: a_ard[k*5 +: 5] = 5'($urandom);
            endcase
         end
         #1;
         for (int k = 0; k < 2; k++) begin
            exp = ref_a(a_ard[k*5 +: 5]);
            n_tests++;
            if (a_rd[k*32 +: 32] !== exp) begin
               n_fail++;
               $display("FAIL random_rd%0d it=%0d addr=%0d: got %h expected %h",
                        k, it, a_ard[k*5 +: 5], a_rd[k*32 +: 32], exp);
            end
         end
         @(posedge clk);
         if (a_we && a_a3 != 5'd0) m_a[a_a3] = a_wd;
      end
      @(negedge clk);
      a_we = 1'b0;
   endtask

   // ------------------------------------------------------------------ sweep
   task automatic test_sweep();
      logic [4:0] bad [3];
      bad[0] = 5'd24; bad[1] = 5'd25; bad[2] = 5'd31;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         b_we = 1'b1; b_a3 = bad[i]; b_wd = 16'hABCD;
         b_ard = {bad[i], bad[i], 5'd1, bad[i]};
         #1;
         n_tests++;
         if (b_rd !== {16'd0, 16'd0, 16'd1, 16'd0}) begin
            n_fail++;
            $display("FAIL sweep_oob_same a=%0d: got %h expected 0000000000010000", bad[i], b_rd);
         end
         @(posedge clk);
         @(negedge clk);
         b_we = 1'b0;
         #1;
         n_tests++;
         if (b_rd !== {16'd0, 16'd0, 16'd1, 16'd0}) begin
            n_fail++;
            $display("FAIL sweep_oob_after a=%0d: got %h expected 0000000000010000", bad[i], b_rd);
         end
      end
      b_we = 1'b1; b_a3 = 5'd23; b_wd = 16'hBEEF;
      b_ard = {5'd23, 5'd3, 5'd2, 5'd1};
      #1;
      n_tests++;
      if (b_rd !== {16'hBEEF, 16'd3, 16'd2, 16'd1}) begin
         n_fail++;
         $display("FAIL sweep_last_bypass: got %h expected %h", b_rd, {16'hBEEF, 16'd3, 16'd2, 16'd1});
      end
      @(posedge clk);
      @(negedge clk);
      b_we = 1'b0;
      b_ard = {5'd23, 5'd23, 5'd0, 5'd22};
      #1;
      n_tests++;
      if (b_rd !== {16'hBEEF, 16'hBEEF, 16'd0, 16'd22}) begin
         n_fail++;
         $display("FAIL sweep_last_commit: got %h expected %h", b_rd, {16'hBEEF, 16'hBEEF, 16'd0, 16'd22});
      end
   endtask

   // ------------------------------------------------------------------ mid-init reset
   task automatic test_mid_init_reset();
      int na;
      na = 0;
      @(negedge clk);
      a_rst = 1'b1;
      a_ard = {5'd7, 5'd3};
      @(posedge clk);
      @(negedge clk);
      #1;
      n_tests++;
      if (a_ready !== 1'b0 || a_rd !== 64'd0) begin
         n_fail++;
         $display("FAIL run_reset: got ready=%b rd=%h expected 0/0", a_ready, a_rd);
      end
      // held reset: counter stays parked, so a full fill is still needed
      repeat (40) @(posedge clk);
      @(negedge clk);
      a_rst = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
      a_rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_rst = 1'b0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         @(posedge clk); @(negedge clk); #1;
         if (a_ready) begin
            na = cyc;
            break;
         end
      end
      n_tests++;
      if (na != 32) begin
         n_fail++;
         $display("FAIL mid_init_len: got %0d expected 32", na);
      end
      #1;
      n_tests++;
      if (a_rd !== {32'd7, 32'd3}) begin
         n_fail++;
         $display("FAIL refill_vals: got %h expected %h", a_rd, {32'd7, 32'd3});
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_zero_reg();
      test_random();
      test_sweep();
      test_mid_init_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
